// File: rtl/uart_rx_os.sv
// UART 8N1 receiver driven by a 16x oversample tick; majority-votes each bit at mid-cell
// and hands bytes out over a valid/ready handshake with framing-error and overrun pulses.
module uart_rx_os #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 tick_os,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned M  = OVERSAMPLE / 2;

    localparam logic [CW-1:0] CNT_SA   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_SB   = CW'(M);
    localparam logic [CW-1:0] CNT_SC   = CW'(M + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   line_idle_q, line_idle_d;
    logic [1:0]             samp_q, samp_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   maj;

    // Third vote is the live synchronised line at cnt = M+1.
    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        line_idle_d = line_idle_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (tick_os) begin
            if (cnt_q == CNT_SA) samp_d[0] = rx_s_q;
            if (cnt_q == CNT_SB) samp_d[1] = rx_s_q;

            unique case (state_q)
                StIdle: begin
                    if (rx_s_q) begin
                        line_idle_d = 1'b1;
                    end else if (line_idle_q) begin
                        state_d     = StStart;
                        cnt_d       = '0;
                        line_idle_d = 1'b0;
                    end
                end
                StStart: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_SC && maj) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = StData;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end
                StData: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_SC) begin
                        shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = StStop;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                StStop: begin
                    cnt_d = cnt_q + 1'b1;
                    // Leave half a bit early so the next start edge is never missed.
                    if (cnt_q == CNT_SC) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        idx_d   = '0;
                        if (maj) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            overrun_d  = rx_valid_q & ~rx_ready;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            line_idle_q <= 1'b0;
            samp_q      <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            line_idle_q <= line_idle_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != StIdle);

endmodule
